argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier.sv | 123 ++++++++++++
 tb/tb_argmax_classifier.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential argmax over up to OUTPUT_SIZE signed 8-bit scores.
// One score is compared per clock. Ties resolve to the lowest index.
// Optional macro ARGMAX_SCORE_OUT_EN adds the max_score output.
module argmax_classifier #(
  parameter int OUTPUT_SIZE = 10,
  parameter int IDX_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [OUTPUT_SIZE*8-1:0] in_vec,
  input  logic [31:0]              actual_size,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic                     busy,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic signed [7:0]        max_score,
`endif
  output logic                     overrun
);

  localparam int NW = $clog2(OUTPUT_SIZE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [OUTPUT_SIZE*8-1:0] vec_q, vec_d;
  logic [NW-1:0]            n_q, n_d;
  logic [NW-1:0]            ptr_q, ptr_d;
  logic signed [7:0]        best_q, best_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic                     overrun_q, overrun_d;

  logic [NW-1:0]            n_cap;
  logic signed [7:0]        elem;

  // Effective size: requested count clamped to the vector capacity
  always_comb begin
    n_cap = (actual_size > 32'(OUTPUT_SIZE)) ? NW'(OUTPUT_SIZE) : NW'(actual_size);
  end

  // Select the registered element under the scan pointer
  always_comb begin
    elem = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++)
      if (ptr_q == NW'(k)) elem = vec_q[k*8 +: 8];
  end

  // Next-state, datapath update and sticky overrun
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    n_d        = n_q;
    ptr_d      = ptr_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    overrun_d  = overrun_q | (in_valid && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d      = in_vec;
          n_d        = n_cap;
          // An empty vector reports the most negative score so element 0 never leaks in
          best_d     = (n_cap == '0) ? 8'sh80 : $signed(in_vec[7:0]);
          best_idx_d = '0;
          ptr_d      = NW'(1);
          state_d    = (n_cap <= NW'(1)) ? DONE : SCAN;
        end
      end
      SCAN: begin
        // Strictly greater keeps the earliest index on ties
        if (elem > best_q) begin
          best_d     = elem;
          best_idx_d = IDX_W'(ptr_q);
        end
        ptr_d = ptr_q + NW'(1);
        if (ptr_q == n_q - NW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      n_q        <= '0;
      ptr_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      n_q        <= n_d;
      ptr_q      <= ptr_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      overrun_q  <= overrun_d;
    end
  end

  // Status and result outputs decoded from registered state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    class_idx = best_idx_q;
    overrun   = overrun_q;
  end

`ifdef ARGMAX_SCORE_OUT_EN
  // Running maximum doubles as the exposed score
  always_comb max_score = best_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier with a small reference argmax.
module tb_argmax_classifier;
  logic        clk, rst, in_valid, out_ready;
  logic [79:0] in_vec;
  logic [31:0] actual_size;
  logic        in_ready, out_valid, busy, overrun;
  logic [7:0]  class_idx;
`ifdef ARGMAX_SCORE_OUT_EN
  logic signed [7:0] max_score;
`endif

  argmax_classifier #(.OUTPUT_SIZE(10), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
    .actual_size(actual_size), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .class_idx(class_idx), .busy(busy),
`ifdef ARGMAX_SCORE_OUT_EN
    .max_score(max_score),
`endif
    .overrun(overrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int sc[10];

  task automatic check(input string tag, input int got, input int exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [79:0] pack();
    logic [79:0] p;
    p = '0;
    for (int k = 0; k < 10; k++) p[k*8 +: 8] = 8'(sc[k]);
    return p;
  endfunction

  function automatic int eff_n(input int size);
    return (size > 10) ? 10 : size;
  endfunction

  // Reference: scan scores in order, first strict maximum wins
  task automatic ref_argmax(input int size, output int idx, output int mx);
    idx = 0; mx = -128;
    for (int k = 0; k < eff_n(size); k++)
      if (sc[k] > mx) begin mx = sc[k]; idx = k; end
  endtask

  function automatic int cur_max();
`ifdef ARGMAX_SCORE_OUT_EN
    return int'(max_score);
`else
    return 0;
`endif
  endfunction

  // Capture sc[], wait for result, accept if out_ready is high
  task automatic run(input int size, output int idx, output int mx, output int lat);
    in_vec = pack(); actual_size = 32'(size); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec = {16'($urandom()), $urandom(), $urandom()};
    actual_size = $urandom();
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (!out_valid) check("result_timeout", 0, 1);
    idx = int'(class_idx);
    mx  = cur_max();
    if (out_ready) tick();
  endtask

  task automatic expect_run(input string tag, input int size);
    int idx, mx, lat, ei, em, el;
    ref_argmax(size, ei, em);
    el = (eff_n(size) <= 1) ? 0 : eff_n(size) - 1;
    run(size, idx, mx, lat);
    check({tag, "_idx"}, idx, ei);
    check({tag, "_lat"}, lat, el);
`ifdef ARGMAX_SCORE_OUT_EN
    check({tag, "_max"}, mx, em);
`endif
  endtask

  initial begin
    int idx0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_vec = '0; actual_size = '0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_class_idx", int'(class_idx), 0);
    check("rst_overrun", int'(overrun), 0);
`ifdef ARGMAX_SCORE_OUT_EN
    check("rst_max", cur_max(), 0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // Ties keep the lower index; full-length latency
    sc = '{3, -5, 7, 7, 0, -128, 1, 2, 6, -1};
    expect_run("n10_tie", 10);
    // All minimum scores
    sc = '{-128, -128, -128, -128, 5, 5, 5, 5, 5, 5};
    expect_run("n4_min", 4);
    // Empty vector
    sc = '{50, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    expect_run("n0", 0);
    // Single score
    sc = '{-7, 100, 2, 3, 4, 5, 6, 7, 8, 9};
    expect_run("n1", 1);
    // Oversized count clamps to capacity
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    expect_run("clamp", 200);
    // Scores beyond N must be ignored
    sc = '{-3, -1, -2, 127, 127, 127, 127, 127, 127, 127};
    expect_run("outside_n", 3);
    check("no_overrun_yet", int'(overrun), 0);

    // Hold result while downstream stalls and upstream keeps pushing
    out_ready = 1'b0;
    sc = '{1, 9, 4, 0, 0, 0, 0, 0, 0, 0};
    begin
      int i0, m0, l0;
      run(3, i0, m0, l0);
      idx0 = i0;
    end
    check("stall_idx", idx0, 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      tick();
      check("stall_hold_idx", int'(class_idx), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    check("overrun_set", int'(overrun), 1);
    out_ready = 1'b1;
    tick();
    check("accept_in_ready", int'(in_ready), 1);
    check("accept_out_valid", int'(out_valid), 0);
    check("overrun_sticky", int'(overrun), 1);

    // Reset while scanning at ptr=4
    sc = '{0, 90, 1, 2, 3, 4, 5, 6, 7, 8};
    in_vec = pack(); actual_size = 32'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("midscan_busy", int'(busy), 1);
    rst = 1'b1; #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_class_idx", int'(class_idx), 0);
    check("abort_overrun", int'(overrun), 0);
    tick();
    rst = 1'b0;
    sc = '{-10, -20, -5, -30, -5, -40, -50, -60, -70, -80};
    expect_run("after_rst", 10);

    // Back-to-back pseudo-random vectors
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 10; k++)
        sc[k] = (i % 2 == 1) ? int'($urandom_range(0, 255)) - 128
                             : int'($urandom_range(0, 6)) - 3;
      expect_run("rand", int'($urandom_range(0, 14)));
    end
    check("final_overrun_clear", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
